// File: rtl/jtag_stream_parser.sv
// Escape-decoding frame parser: JTAG-UART byte stream in, unescaped pixel FIFO writes out.
// Define PARSER_CHECKSUM_EN to require a trailing checksum byte after the EOF code.
module jtag_stream_parser #(
    parameter int PIXEL_COUNT = 786432,
    parameter int CNT_W       = 20
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic [7:0]       iDATA,
    input  logic             iDATA_VALID,
    input  logic             iFIFO_FULL,
    output logic             oFIFO_WRREQ,
    output logic [7:0]       oFIFO_WRDATA,
    output logic [7:0]       oFRAME_ID,
    output logic             oFRAME_DONE,
    output logic             oBUSY,
    output logic             oERROR,
    output logic [2:0]       oERR_CODE,
    output logic [CNT_W-1:0] oPIXEL_COUNT
);

    localparam logic [7:0] ESC_BYTE   = 8'hFE;
    localparam logic [2:0] ERR_CODE   = 3'd1;
    localparam logic [2:0] ERR_FRAME  = 3'd2;
    localparam logic [2:0] ERR_FULL   = 3'd3;
    localparam logic [2:0] ERR_SUM    = 3'd4;
    localparam logic [2:0] ERR_EXTRA  = 3'd5;

`ifdef PARSER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_PIX, S_EOF, S_ERROR, S_CHK} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_PIX, S_EOF, S_ERROR} state_t;
`endif

    state_t           state, state_next;
    logic             esc, esc_next;
    logic             wr_req_next;
    logic [7:0]       wr_data_next, frame_id_next;
    logic             done_next;
    logic [2:0]       err_code_next;
    logic [CNT_W-1:0] count_next;
    logic [CNT_W:0]   count_inc;
    logic             is_data, is_sof, is_eof, is_resync, is_bad;
`ifdef PARSER_CHECKSUM_EN
    logic [7:0]       checksum, checksum_next;
`endif

    assign count_inc = {1'b0, oPIXEL_COUNT} + 1'b1;

    // Escape layer: classify this cycle's byte into data / control events.
    always_comb begin
        esc_next  = esc;
        is_data   = 1'b0;
        is_sof    = 1'b0;
        is_eof    = 1'b0;
        is_resync = 1'b0;
        is_bad    = 1'b0;
        if (iDATA_VALID) begin
            if (!esc) begin
                if (iDATA == ESC_BYTE) esc_next = 1'b1;
                else                   is_data  = 1'b1;
            end else begin
                esc_next = 1'b0;
                case (iDATA)
                    ESC_BYTE: is_data   = 1'b1;
                    8'h00:    is_resync = 1'b1;
                    8'h01:    is_sof    = 1'b1;
                    8'h02:    is_eof    = 1'b1;
                    default:  is_bad    = 1'b1;
                endcase
            end
        end
    end

    always_comb begin
        state_next    = state;
        wr_req_next   = 1'b0;
        wr_data_next  = oFIFO_WRDATA;
        frame_id_next = oFRAME_ID;
        done_next     = 1'b0;
        err_code_next = oERR_CODE;
        count_next    = oPIXEL_COUNT;
`ifdef PARSER_CHECKSUM_EN
        checksum_next = checksum;
`endif
        if (is_resync) begin
            state_next    = S_IDLE;
            err_code_next = 3'd0;
            count_next    = '0;
`ifdef PARSER_CHECKSUM_EN
            checksum_next = 8'd0;
`endif
        end else if (is_bad && state != S_ERROR) begin
            state_next    = S_ERROR;
            err_code_next = ERR_CODE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (is_sof) begin
                        state_next = S_HDR;
                        count_next = '0;
`ifdef PARSER_CHECKSUM_EN
                        checksum_next = 8'd0;
`endif
                    end else if (is_eof) begin
                        state_next    = S_ERROR;
                        err_code_next = ERR_FRAME;
                    end
                end
                S_HDR: begin
                    if (is_data) begin
                        state_next    = S_PIX;
                        frame_id_next = iDATA;
                        count_next    = '0;
`ifdef PARSER_CHECKSUM_EN
                        checksum_next = iDATA;
`endif
                    end else if (is_sof || is_eof) begin
                        state_next    = S_ERROR;
                        err_code_next = ERR_FRAME;
                    end
                end
                S_PIX: begin
                    if (is_data && iFIFO_FULL) begin
                        state_next    = S_ERROR;
                        err_code_next = ERR_FULL;
                    end else if (is_data) begin
                        wr_req_next  = 1'b1;
                        wr_data_next = iDATA;
                        count_next   = count_inc[CNT_W-1:0];
`ifdef PARSER_CHECKSUM_EN
                        checksum_next = checksum + iDATA;
`endif
                        if (count_inc == (CNT_W+1)'(PIXEL_COUNT)) state_next = S_EOF;
                    end else if (is_sof || is_eof) begin
                        state_next    = S_ERROR;
                        err_code_next = ERR_FRAME;
                    end
                end
                S_EOF: begin
                    if (is_eof) begin
`ifdef PARSER_CHECKSUM_EN
                        state_next = S_CHK;
`else
                        state_next = S_IDLE;
                        done_next  = 1'b1;
`endif
                    end else if (is_data) begin
                        state_next    = S_ERROR;
                        err_code_next = ERR_EXTRA;
                    end else if (is_sof) begin
                        state_next    = S_ERROR;
                        err_code_next = ERR_FRAME;
                    end
                end
`ifdef PARSER_CHECKSUM_EN
                S_CHK: begin
                    if (is_data && iDATA == checksum) begin
                        state_next = S_IDLE;
                        done_next  = 1'b1;
                    end else if (is_data) begin
                        state_next    = S_ERROR;
                        err_code_next = ERR_SUM;
                    end else if (is_sof || is_eof) begin
                        state_next    = S_ERROR;
                        err_code_next = ERR_FRAME;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state        <= S_IDLE;
            esc          <= 1'b0;
            oFIFO_WRREQ  <= 1'b0;
            oFIFO_WRDATA <= 8'd0;
            oFRAME_ID    <= 8'd0;
            oFRAME_DONE  <= 1'b0;
            oERR_CODE    <= 3'd0;
            oPIXEL_COUNT <= '0;
`ifdef PARSER_CHECKSUM_EN
            checksum     <= 8'd0;
`endif
        end else begin
            state        <= state_next;
            esc          <= esc_next;
            oFIFO_WRREQ  <= wr_req_next;
            oFIFO_WRDATA <= wr_data_next;
            oFRAME_ID    <= frame_id_next;
            oFRAME_DONE  <= done_next;
            oERR_CODE    <= err_code_next;
            oPIXEL_COUNT <= count_next;
`ifdef PARSER_CHECKSUM_EN
            checksum     <= checksum_next;
`endif
        end
    end

    assign oERROR = (state == S_ERROR);
`ifdef PARSER_CHECKSUM_EN
    assign oBUSY  = (state == S_HDR) || (state == S_PIX) || (state == S_EOF) || (state == S_CHK);
`else
    assign oBUSY  = (state == S_HDR) || (state == S_PIX) || (state == S_EOF);
`endif

endmodule

// File: tb/tb_jtag_stream_parser.sv
// Directed bench for jtag_stream_parser (PIXEL_COUNT=4) with a pixel-write scoreboard queue.
module tb_jtag_stream_parser;

    localparam int CNT_W = 20;

    logic             iCLK = 1'b0;
    logic             iRST_N;
    logic [7:0]       iDATA;
    logic             iDATA_VALID;
    logic             iFIFO_FULL;
    logic             oFIFO_WRREQ;
    logic [7:0]       oFIFO_WRDATA;
    logic [7:0]       oFRAME_ID;
    logic             oFRAME_DONE;
    logic             oBUSY;
    logic             oERROR;
    logic [2:0]       oERR_CODE;
    logic [CNT_W-1:0] oPIXEL_COUNT;

    int         checks = 0;
    int         errors = 0;
    int         done_count = 0;
    logic [7:0] exp_q[$];

`ifdef PARSER_CHECKSUM_EN
    localparam logic [2:0] EXTRA_BYTE_CODE = 3'd4;
`else
    localparam logic [2:0] EXTRA_BYTE_CODE = 3'd5;
`endif

    jtag_stream_parser #(.PIXEL_COUNT(4), .CNT_W(CNT_W)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iDATA(iDATA), .iDATA_VALID(iDATA_VALID),
        .iFIFO_FULL(iFIFO_FULL), .oFIFO_WRREQ(oFIFO_WRREQ), .oFIFO_WRDATA(oFIFO_WRDATA),
        .oFRAME_ID(oFRAME_ID), .oFRAME_DONE(oFRAME_DONE), .oBUSY(oBUSY), .oERROR(oERROR),
        .oERR_CODE(oERR_CODE), .oPIXEL_COUNT(oPIXEL_COUNT)
    );

    always #5 iCLK = ~iCLK;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest expected pixel.
    always @(negedge iCLK) begin
        if (iRST_N) begin
            if (oFIFO_WRREQ) begin
                if (exp_q.size() == 0) check_output("wr_unexpected_queue_depth", 32'(exp_q.size()), 32'd1);
                else                   check_output("wr_data", {24'd0, oFIFO_WRDATA}, {24'd0, exp_q.pop_front()});
            end
            if (oFRAME_DONE) done_count++;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        iDATA       = b;
        iDATA_VALID = 1'b1;
        @(posedge iCLK);
        #1;
        iDATA_VALID = 1'b0;
    endtask

    task automatic send_data(input logic [7:0] b);
        if (b == 8'hFE) send_byte(8'hFE);
        send_byte(b);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge iCLK);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] id, input logic [31:0] px, input bit bad_sum);
        logic [7:0] sum;
        logic [7:0] b;
        sum = id;
        send_byte(8'hFE); send_byte(8'h01);
        send_data(id);
        for (int i = 0; i < 4; i++) begin
            b = px[31-8*i -: 8];
            exp_q.push_back(b);
            sum = sum + b;
            send_data(b);
        end
        send_byte(8'hFE); send_byte(8'h02);
`ifdef PARSER_CHECKSUM_EN
        send_data(bad_sum ? sum + 8'd1 : sum);
`else
        if (bad_sum) sum = 8'd0;
`endif
    endtask

    task automatic check_status(input string tag, input int exp_done, input logic exp_err,
                                input logic [2:0] exp_code, input int exp_count, input logic [7:0] exp_id);
        idle(3);
        check_output({tag, ".done"}, 32'(done_count), 32'(exp_done));
        check_output({tag, ".error"}, {31'd0, oERROR}, {31'd0, exp_err});
        check_output({tag, ".err_code"}, {29'd0, oERR_CODE}, {29'd0, exp_code});
        check_output({tag, ".count"}, {12'd0, oPIXEL_COUNT}, 32'(exp_count));
        check_output({tag, ".frame_id"}, {24'd0, oFRAME_ID}, {24'd0, exp_id});
        check_output({tag, ".busy"}, {31'd0, oBUSY}, 32'd0);
        check_output({tag, ".pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, ".wrreq"}, {31'd0, oFIFO_WRREQ}, 32'd0);
        check_output({tag, ".wrdata"}, {24'd0, oFIFO_WRDATA}, 32'd0);
        check_output({tag, ".frame_id"}, {24'd0, oFRAME_ID}, 32'd0);
        check_output({tag, ".done"}, {31'd0, oFRAME_DONE}, 32'd0);
        check_output({tag, ".busy"}, {31'd0, oBUSY}, 32'd0);
        check_output({tag, ".error"}, {31'd0, oERROR}, 32'd0);
        check_output({tag, ".err_code"}, {29'd0, oERR_CODE}, 32'd0);
        check_output({tag, ".count"}, {12'd0, oPIXEL_COUNT}, 32'd0);
    endtask

    initial begin
        iRST_N = 1'b0; iDATA = 8'd0; iDATA_VALID = 1'b0; iFIFO_FULL = 1'b0;
        #12;
        check_all_zero("reset");
        @(negedge iCLK);
        iRST_N = 1'b1;
        idle(2);

        $display("[TB] plain frame");
        send_frame(8'h07, 32'h10203040, 1'b0);
        check_status("t1", 1, 1'b0, 3'd0, 4, 8'h07);

        $display("[TB] literal FE pixels");
        send_frame(8'h01, 32'hFE11FE22, 1'b0);
        check_status("t2", 2, 1'b0, 3'd0, 4, 8'h01);
`ifdef PARSER_CHECKSUM_EN
        send_frame(8'h01, 32'h01020304, 1'b1);
        check_status("t2_badsum", 2, 1'b1, 3'd4, 4, 8'h01);
        send_byte(8'hFE); send_byte(8'h00);
`endif

        $display("[TB] early EOF then resync");
        send_byte(8'hFE); send_byte(8'h01); send_byte(8'h05);
        idle(1);
        check_output("t3.busy_mid", {31'd0, oBUSY}, 32'd1);
        exp_q.push_back(8'hAA); exp_q.push_back(8'hBB);
        send_byte(8'hAA); send_byte(8'hBB);
        send_byte(8'hFE); send_byte(8'h02);
        check_status("t3_err", 2, 1'b1, 3'd2, 2, 8'h05);
        send_byte(8'hFE); send_byte(8'h00);
        check_status("t3_resync", 2, 1'b0, 3'd0, 0, 8'h05);
        send_frame(8'h08, 32'h01020304, 1'b0);
        check_status("t3_after", 3, 1'b0, 3'd0, 4, 8'h08);

        $display("[TB] FIFO full drop");
        send_byte(8'hFE); send_byte(8'h01); send_byte(8'h06);
        exp_q.push_back(8'hA1); exp_q.push_back(8'hA2);
        send_byte(8'hA1); send_byte(8'hA2);
        iFIFO_FULL = 1'b1;
        send_byte(8'hA3);
        iFIFO_FULL = 1'b0;
        send_byte(8'hA4); send_byte(8'hFE); send_byte(8'h02);
        check_status("t4", 3, 1'b1, 3'd3, 2, 8'h06);
        send_byte(8'hFE); send_byte(8'h00);

        $display("[TB] bad code and escape across gaps");
        send_byte(8'hFE); send_byte(8'h05);
        check_status("t5_bad", 3, 1'b1, 3'd1, 0, 8'h06);
        send_byte(8'hFE); send_byte(8'h00);
        send_byte(8'hFE); send_byte(8'h01); send_byte(8'h09);
        exp_q.push_back(8'h51); exp_q.push_back(8'hFE);
        exp_q.push_back(8'h52); exp_q.push_back(8'h53);
        send_byte(8'h51);
        send_byte(8'hFE); idle(3); send_byte(8'hFE); idle(2);
        send_byte(8'h52); send_byte(8'h53);
        send_byte(8'hFE); send_byte(8'h02);
`ifdef PARSER_CHECKSUM_EN
        send_data(8'h09 + 8'h51 + 8'hFE + 8'h52 + 8'h53);
`endif
        check_status("t5_gap", 4, 1'b0, 3'd0, 4, 8'h09);

        $display("[TB] EOF while idle, extra byte after last pixel");
        send_byte(8'hFE); send_byte(8'h02);
        check_status("idle_eof", 4, 1'b1, 3'd2, 4, 8'h09);
        send_byte(8'hFE); send_byte(8'h00);
        send_byte(8'hFE); send_byte(8'h01); send_byte(8'h0B);
        exp_q.push_back(8'hC1); exp_q.push_back(8'hC2);
        exp_q.push_back(8'hC3); exp_q.push_back(8'hC4);
        send_byte(8'hC1); send_byte(8'hC2); send_byte(8'hC3); send_byte(8'hC4);
`ifdef PARSER_CHECKSUM_EN
        send_byte(8'hFE); send_byte(8'h02);
`endif
        send_byte(8'h77);
        check_status("extra_byte", 4, 1'b1, EXTRA_BYTE_CODE, 4, 8'h0B);
        send_byte(8'hFE); send_byte(8'h00);

        $display("[TB] async reset mid-frame");
        send_byte(8'hFE); send_byte(8'h01); send_byte(8'h0A);
        exp_q.push_back(8'h61); exp_q.push_back(8'h62);
        send_byte(8'h61); send_byte(8'h62);
        @(negedge iCLK);
        #1;
        iRST_N = 1'b0;
        #1;
        check_all_zero("t6_reset");
        check_output("t6.pending", 32'(exp_q.size()), 32'd0);
        @(negedge iCLK);
        iRST_N = 1'b1;
        idle(1);
        send_frame(8'h0C, 32'h0D0E0F10, 1'b0);
        check_status("t6_after", 5, 1'b0, 3'd0, 4, 8'h0C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
